// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked sequential ALU between operand fetch and writeback.
//
// One operation is accepted per valid/ready transaction. Add/sub/inc/dec,
// logic and shift operations finish in a single cycle. Unsigned multiply
// (low/high half) and restoring divide (quotient/remainder) iterate one bit
// per cycle for WIDTH cycles. The result, destination address and compare
// flags are held in registers until downstream consumes them.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operation request
//   in_ready     out  request can be accepted this cycle
//   mode         in   [1:0] 00 pass/address, 01 arith, 10 logic, 11 reserved
//   opcode       in   [3:0] operation within mode
//   op1, op2     in   [WIDTH-1:0] operands A and B
//   op1_regaddr  in   [ADDR_W-1:0] destination for arith/logic results
//   op2_regaddr  in   [ADDR_W-1:0] destination for pass mode
//   out_valid    out  result registers valid
//   out_ready    in   downstream consumes the result
//   alu_out      out  [WIDTH-1:0] result
//   addr_out     out  [ADDR_W-1:0] destination address
//   za zb eq gt lt out unsigned compare flags of the accepted operands
//   cout         out  carry (ADD/INC) or inverted borrow (SUB/DEC)
//   dz           out  divide by zero on DIV/REM
//   err          out  reserved mode or undefined opcode
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16,
   parameter int SH_W   = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        mode,
   input  logic [3:0]        opcode,
   input  logic [WIDTH-1:0]  op1,
   input  logic [WIDTH-1:0]  op2,
   input  logic [ADDR_W-1:0] op1_regaddr,
   input  logic [ADDR_W-1:0] op2_regaddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  alu_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic              za,
   output logic              zb,
   output logic              eq,
   output logic              gt,
   output logic              lt,
   output logic              cout,
   output logic              dz,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Iterative operation kinds, encoded as opcode[1:0] of arith opcodes 4..7.
   localparam logic [1:0] MOP_MUL  = 2'b00;
   localparam logic [1:0] MOP_MULH = 2'b01;
   localparam logic [1:0] MOP_DIV  = 2'b10;

   // Control and iteration state
   state_t            state_r;
   logic [SH_W-1:0]   cnt_r;
   logic [1:0]        mop_r;
   logic [WIDTH-1:0]  acc_hi_r;     // mul: partial product high half / div: remainder
   logic [WIDTH-1:0]  acc_lo_r;     // mul: multiplier bits / div: dividend -> quotient
   logic [WIDTH-1:0]  oper_r;       // mul: multiplicand / div: divisor
   logic [ADDR_W-1:0] addr_pend_r;

   // Output registers
   logic              out_valid_r;
   logic [WIDTH-1:0]  alu_out_r;
   logic [ADDR_W-1:0] addr_out_r;
   logic              za_r;
   logic              zb_r;
   logic              eq_r;
   logic              gt_r;
   logic              lt_r;
   logic              cout_r;
   logic              dz_r;
   logic              err_r;

   // Combinational helpers
   logic              acc_s;
   logic [SH_W-1:0]   shamt_s;
   logic [WIDTH:0]    sum_w_s;
   logic [WIDTH:0]    dif_w_s;
   logic [WIDTH:0]    inc_w_s;
   logic [WIDTH:0]    dec_w_s;
   logic [WIDTH-1:0]  sc_res_s;
   logic              sc_cout_s;
   logic              sc_err_s;
   logic [ADDR_W-1:0] sc_addr_s;
   logic              is_multi_s;
   logic [WIDTH:0]    mul_sum_s;
   logic [WIDTH-1:0]  mul_hi_nx_s;
   logic [WIDTH-1:0]  mul_lo_nx_s;
   logic [WIDTH:0]    div_sh_s;
   logic [WIDTH-1:0]  div_diff_s;
   logic              div_ge_s;
   logic [WIDTH-1:0]  div_rem_nx_s;
   logic [WIDTH-1:0]  div_q_nx_s;
   logic [WIDTH-1:0]  mc_res_s;

   // in_ready is combinational on out_ready so a consume and a new accept
   // can share one edge; out_ready only matters while out_valid is high,
   // which coincides with ST_DONE.
   assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
   assign acc_s    = in_valid && in_ready;

   assign shamt_s  = op2[SH_W-1:0];
   assign sum_w_s  = {1'b0, op1} + {1'b0, op2};
   assign dif_w_s  = {1'b0, op1} - {1'b0, op2};
   assign inc_w_s  = {1'b0, op1} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_w_s  = {1'b0, op1} - {{WIDTH{1'b0}}, 1'b1};

   // Single-cycle result, carry, error and destination for the incoming request
   always_comb begin
      sc_res_s   = {WIDTH{1'b0}};
      sc_cout_s  = 1'b0;
      sc_err_s   = 1'b0;
      sc_addr_s  = op1_regaddr;
      is_multi_s = 1'b0;
      case (mode)
         2'b00: begin
            sc_res_s  = op2;
            sc_addr_s = op2_regaddr;
         end
         2'b01: begin
            case (opcode)
               4'd0: begin
                  sc_res_s  = sum_w_s[WIDTH-1:0];
                  sc_cout_s = sum_w_s[WIDTH];
               end
               4'd1: begin
                  sc_res_s  = dif_w_s[WIDTH-1:0];
                  sc_cout_s = ~dif_w_s[WIDTH];
               end
               4'd2: begin
                  sc_res_s  = inc_w_s[WIDTH-1:0];
                  sc_cout_s = inc_w_s[WIDTH];
               end
               4'd3: begin
                  sc_res_s  = dec_w_s[WIDTH-1:0];
                  sc_cout_s = ~dec_w_s[WIDTH];
               end
               4'd4, 4'd5, 4'd6, 4'd7: is_multi_s = 1'b1;
               default: sc_err_s = 1'b1;
            endcase
         end
         2'b10: begin
            case (opcode)
               4'd0:    sc_res_s = op1 & op2;
               4'd1:    sc_res_s = op1 | op2;
               4'd2:    sc_res_s = op1 ^ op2;
               4'd3:    sc_res_s = ~op1;
               4'd4:    sc_res_s = op1 << shamt_s;
               4'd5:    sc_res_s = op1 >> shamt_s;
               4'd6:    sc_res_s = $unsigned($signed(op1) >>> shamt_s);
               4'd7:    sc_res_s = op1;
               default: sc_err_s = 1'b1;
            endcase
         end
         default: begin
            sc_addr_s = {ADDR_W{1'b0}};
            sc_err_s  = 1'b1;
         end
      endcase
   end

   // One shift-add multiply step: add multiplicand if the current multiplier
   // bit is set, then shift the {carry, hi, lo} chain right by one.
   assign mul_sum_s   = {1'b0, acc_hi_r} + ({1'b0, oper_r} & {(WIDTH+1){acc_lo_r[0]}});
   assign mul_hi_nx_s = mul_sum_s[WIDTH:1];
   assign mul_lo_nx_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};

   // One restoring-divide step. The partial remainder stays below the divisor,
   // so the trial difference always fits WIDTH bits when it is kept. A zero
   // divisor makes every step succeed: quotient all ones, remainder = dividend.
   assign div_sh_s     = {acc_hi_r, acc_lo_r[WIDTH-1]};
   assign div_ge_s     = (div_sh_s >= {1'b0, oper_r});
   assign div_diff_s   = div_sh_s[WIDTH-1:0] - oper_r;
   assign div_rem_nx_s = div_ge_s ? div_diff_s : div_sh_s[WIDTH-1:0];
   assign div_q_nx_s   = {acc_lo_r[WIDTH-2:0], div_ge_s};

   // Final iterative result selected from the values produced by the last step
   always_comb begin
      mc_res_s = {WIDTH{1'b0}};
      case (mop_r)
         MOP_MUL:  mc_res_s = mul_lo_nx_s;
         MOP_MULH: mc_res_s = mul_hi_nx_s;
         MOP_DIV:  mc_res_s = div_q_nx_s;
         default:  mc_res_s = div_rem_nx_s;
      endcase
   end

   // Control FSM with iteration datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {SH_W{1'b0}};
         mop_r       <= 2'b00;
         acc_hi_r    <= {WIDTH{1'b0}};
         acc_lo_r    <= {WIDTH{1'b0}};
         oper_r      <= {WIDTH{1'b0}};
         addr_pend_r <= {ADDR_W{1'b0}};
         out_valid_r <= 1'b0;
         alu_out_r   <= {WIDTH{1'b0}};
         addr_out_r  <= {ADDR_W{1'b0}};
         za_r        <= 1'b0;
         zb_r        <= 1'b0;
         eq_r        <= 1'b0;
         gt_r        <= 1'b0;
         lt_r        <= 1'b0;
         cout_r      <= 1'b0;
         dz_r        <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_BUSY: begin
               // in_valid is ignored here: in_ready is low throughout BUSY
               acc_hi_r <= mop_r[1] ? div_rem_nx_s : mul_hi_nx_s;
               acc_lo_r <= mop_r[1] ? div_q_nx_s   : mul_lo_nx_s;
               cnt_r    <= cnt_r - {{(SH_W-1){1'b0}}, 1'b1};
               if (cnt_r == {SH_W{1'b0}}) begin
                  state_r     <= ST_DONE;
                  out_valid_r <= 1'b1;
                  alu_out_r   <= mc_res_s;
                  addr_out_r  <= addr_pend_r;
                  cout_r      <= 1'b0;
                  err_r       <= 1'b0;
                  dz_r        <= mop_r[1] && (oper_r == {WIDTH{1'b0}});
               end
            end
            ST_IDLE, ST_DONE: begin
               if (acc_s) begin
                  za_r <= (op1 == {WIDTH{1'b0}});
                  zb_r <= (op2 == {WIDTH{1'b0}});
                  eq_r <= (op1 == op2);
                  gt_r <= (op1 > op2);
                  lt_r <= (op1 < op2);
                  if (is_multi_s) begin
                     state_r     <= ST_BUSY;
                     out_valid_r <= 1'b0;
                     cnt_r       <= SH_W'(WIDTH - 1);
                     mop_r       <= opcode[1:0];
                     addr_pend_r <= op1_regaddr;
                     acc_hi_r    <= {WIDTH{1'b0}};
                     // divide works on the dividend in acc_lo, multiply
                     // walks the multiplier bits through acc_lo
                     acc_lo_r    <= opcode[1] ? op1 : op2;
                     oper_r      <= opcode[1] ? op2 : op1;
                  end else begin
                     state_r     <= ST_DONE;
                     out_valid_r <= 1'b1;
                     alu_out_r   <= sc_res_s;
                     addr_out_r  <= sc_addr_s;
                     cout_r      <= sc_cout_s;
                     dz_r        <= 1'b0;
                     err_r       <= sc_err_s;
                  end
               end else if ((state_r == ST_DONE) && out_ready) begin
                  // consume without a new request; result registers keep value
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign alu_out   = alu_out_r;
   assign addr_out  = addr_out_r;
   assign za        = za_r;
   assign zb        = zb_r;
   assign eq        = eq_r;
   assign gt        = gt_r;
   assign lt        = lt_r;
   assign cout      = cout_r;
   assign dz        = dz_r;
   assign err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH=16).
// Inputs change on the falling edge, outputs are sampled on the falling edge
// (or shortly after an asynchronous reset event).
// ---------------------------------------------------------------------------
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  mode;
   logic [3:0]  opcode;
   logic [15:0] op1;
   logic [15:0] op2;
   logic [15:0] op1_regaddr;
   logic [15:0] op2_regaddr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] alu_out;
   logic [15:0] addr_out;
   logic        za, zb, eq, gt, lt, cout, dz, err;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0]  m;
      logic [3:0]  opc;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        c;
      logic        e;
   } vec_t;

   vec_t vecs [14] = '{
      '{2'b01, 4'd1,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0},
      '{2'b01, 4'd1,  16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0},
      '{2'b01, 4'd2,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0},
      '{2'b01, 4'd3,  16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0},
      '{2'b01, 4'd9,  16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b1},
      '{2'b10, 4'd1,  16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0},
      '{2'b10, 4'd3,  16'h0F0F, 16'h0000, 16'hF0F0, 1'b0, 1'b0},
      '{2'b10, 4'd4,  16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0},
      '{2'b10, 4'd5,  16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0},
      '{2'b10, 4'd6,  16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0},
      '{2'b10, 4'd6,  16'h4000, 16'h0004, 16'h0400, 1'b0, 1'b0},
      '{2'b10, 4'd12, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1},
      '{2'b01, 4'd0,  16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0},
      '{2'b10, 4'd7,  16'h5A5A, 16'h0000, 16'h5A5A, 1'b0, 1'b0}
   };

   alu_seq #(.WIDTH(16), .ADDR_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mode        (mode),
      .opcode      (opcode),
      .op1         (op1),
      .op2         (op2),
      .op1_regaddr (op1_regaddr),
      .op2_regaddr (op2_regaddr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_out     (alu_out),
      .addr_out    (addr_out),
      .za          (za),
      .zb          (zb),
      .eq          (eq),
      .gt          (gt),
      .lt          (lt),
      .cout        (cout),
      .dz          (dz),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one request at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic [1:0] m, input logic [3:0] opc, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] ra1, input logic [15:0] ra2);
      mode = m; opcode = opc; op1 = a; op2 = b;
      op1_regaddr = ra1; op2_regaddr = ra2;
      in_valid = 1'b1;
      #1;
      check_eq("ready_at_send", 32'(in_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, counting busy cycles and offering junk requests meanwhile.
   task automatic wait_done(input string tag, input int exp_busy);
      int busy = 0;
      int n    = 0;
      while (!out_valid && n < 60) begin
         if (!in_ready) begin
            busy++;
            in_valid = 1'b1; mode = 2'b11; op1 = 16'hDEAD; op2 = 16'hBEEF;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check_eq({tag, "_valid"}, 32'(out_valid), 32'h1);
      check_eq({tag, "_busy"}, 32'(busy), 32'(exp_busy));
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_drop"}, 32'(out_valid), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int vcnt;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mode = 2'b00; opcode = 4'h0; op1 = 16'h0; op2 = 16'h0;
      op1_regaddr = 16'h0; op2_regaddr = 16'h0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(in_ready), 32'h1);
      check_eq("rst_valid", 32'(out_valid), 32'h0);
      check_eq("rst_alu", 32'(alu_out), 32'h0);
      check_eq("rst_addr", 32'(addr_out), 32'h0);
      check_eq("rst_flags", 32'({za, zb, eq, gt, lt, cout, dz, err}), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD with latency 1
      send(2'b01, 4'd0, 16'h7FFF, 16'h0001, 16'h0011, 16'h0022);
      check_eq("add_valid", 32'(out_valid), 32'h1);
      check_eq("add_res", 32'(alu_out), 32'h8000);
      check_eq("add_cout", 32'(cout), 32'h0);
      check_eq("add_flags", 32'({za, zb, eq, gt, lt}), 32'b00010);
      check_eq("add_addr", 32'(addr_out), 32'h0011);
      consume("add");
      check_eq("add_retain", 32'(alu_out), 32'h8000);

      // Iterative multiply / divide
      send(2'b01, 4'd4, 16'h0123, 16'h0045, 16'h0031, 16'h0000);
      wait_done("mul", 16);
      check_eq("mul_res", 32'(alu_out), 32'h4E6F);
      check_eq("mul_addr", 32'(addr_out), 32'h0031);
      check_eq("mul_err", 32'({cout, dz, err}), 32'h0);
      consume("mul");

      send(2'b01, 4'd5, 16'hFFFF, 16'hFFFF, 16'h0032, 16'h0000);
      wait_done("mulh", 16);
      check_eq("mulh_res", 32'(alu_out), 32'hFFFE);
      check_eq("mulh_eq", 32'(eq), 32'h1);
      consume("mulh");

      send(2'b01, 4'd6, 16'h03E8, 16'h0007, 16'h0033, 16'h0000);
      wait_done("div", 16);
      check_eq("div_res", 32'(alu_out), 32'h008E);
      check_eq("div_dz", 32'(dz), 32'h0);
      consume("div");

      send(2'b01, 4'd7, 16'h03E8, 16'h0007, 16'h0034, 16'h0000);
      wait_done("rem", 16);
      check_eq("rem_res", 32'(alu_out), 32'h0006);
      consume("rem");

      send(2'b01, 4'd6, 16'h03E8, 16'h0000, 16'h0035, 16'h0000);
      wait_done("div0", 16);
      check_eq("div0_res", 32'(alu_out), 32'hFFFF);
      check_eq("div0_dz", 32'(dz), 32'h1);
      check_eq("div0_zb", 32'(zb), 32'h1);
      consume("div0");

      send(2'b01, 4'd7, 16'h03E8, 16'h0000, 16'h0036, 16'h0000);
      wait_done("rem0", 16);
      check_eq("rem0_res", 32'(alu_out), 32'h03E8);
      check_eq("rem0_dz", 32'(dz), 32'h1);
      consume("rem0");

      // XOR held under back-pressure, then back-to-back accept with consume
      send(2'b10, 4'd2, 16'hF0F0, 16'h0FF0, 16'h0041, 16'h0000);
      check_eq("xor_res", 32'(alu_out), 32'hFF00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("hold_res", 32'(alu_out), 32'hFF00);
         check_eq("hold_state", 32'({in_ready, out_valid}), 32'b01);
      end
      out_ready = 1'b1;
      mode = 2'b10; opcode = 4'd0; op1 = 16'hF0F0; op2 = 16'h0FF0; op1_regaddr = 16'h0042;
      in_valid = 1'b1;
      #1;
      check_eq("b2b_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      check_eq("b2b_valid", 32'(out_valid), 32'h1);
      check_eq("b2b_res", 32'(alu_out), 32'h00F0);
      check_eq("b2b_addr", 32'(addr_out), 32'h0042);
      consume("b2b");

      // Pass mode and reserved mode
      send(2'b00, 4'hA, 16'h1111, 16'hBEEF, 16'h0009, 16'h0005);
      check_eq("pass_res", 32'(alu_out), 32'hBEEF);
      check_eq("pass_addr", 32'(addr_out), 32'h0005);
      check_eq("pass_err", 32'(err), 32'h0);
      consume("pass");

      send(2'b11, 4'd0, 16'h1234, 16'h1234, 16'h0009, 16'h0005);
      check_eq("m11_res", 32'(alu_out), 32'h0);
      check_eq("m11_addr", 32'(addr_out), 32'h0);
      check_eq("m11_err", 32'(err), 32'h1);
      check_eq("m11_eq", 32'(eq), 32'h1);
      consume("m11");

      // Single-cycle vector table
      for (int i = 0; i < 14; i++) begin
         send(vecs[i].m, vecs[i].opc, vecs[i].a, vecs[i].b, 16'(i + 16'h0100), 16'h0000);
         check_eq($sformatf("vec%0d_res", i), 32'(alu_out), 32'(vecs[i].res));
         check_eq($sformatf("vec%0d_cde", i), 32'({cout, dz, err}),
                  32'({vecs[i].c, 1'b0, vecs[i].e}));
         check_eq($sformatf("vec%0d_addr", i), 32'(addr_out), 32'(i + 16'h0100));
         consume($sformatf("vec%0d", i));
      end

      // Reset during MUL busy cycle 8
      send(2'b01, 4'd4, 16'h0123, 16'h0045, 16'h0077, 16'h0000);
      repeat (7) @(negedge clk);
      check_eq("pre_rst_busy", 32'({in_ready, out_valid}), 32'b00);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", 32'(out_valid), 32'h0);
      check_eq("midrst_ready", 32'(in_ready), 32'h1);
      check_eq("midrst_alu", 32'(alu_out), 32'h0);
      check_eq("midrst_addr", 32'(addr_out), 32'h0);
      check_eq("midrst_flags", 32'({za, zb, eq, gt, lt, cout, dz, err}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) vcnt++;
      end
      check_eq("postrst_no_valid", 32'(vcnt), 32'h0);
      send(2'b01, 4'd0, 16'h0002, 16'h0003, 16'h0055, 16'h0000);
      check_eq("postrst_valid", 32'(out_valid), 32'h1);
      check_eq("postrst_res", 32'(alu_out), 32'h0005);
      check_eq("postrst_addr", 32'(addr_out), 32'h0055);
      consume("postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
